// File: rtl/mem_ctrl_pkg.sv
// Shared types, constants and the address-legality helper for the
// memory access arbiter.
package mem_ctrl_pkg;

  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 32;
  localparam int MEM_BYTES  = 256;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Out-of-range, or a word access that is not on a word boundary.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input logic byte_op);
    logic oob;
    logic misaligned;
    oob        = (addr >= ADDR_W'(MEM_BYTES));
    misaligned = !byte_op && (addr[1:0] != 2'b00);
    return oob | misaligned;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  // Grant index selection
  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the 256-byte data memory between instruction fetch (port 0) and the
// load/store unit (port 1); each access runs IDLE -> ACCESS -> RESP.
module mem_access_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_byte,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_byte,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e              state_r, next_state_s;
  logic [1:0]          req_s;
  logic                grant_s;
  logic                last_grant_r;
  logic                win_r;
  logic                err_r;
  logic                sel_we_s, sel_byte_s, sel_err_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [DATA_W-1:0]   rd_s;
  logic [ADDR_W-1:0]   mem_address_r;
  logic [DATA_W-1:0]   mem_write_data_r;
  logic                mem_read_r, mem_write_r, mem_byte_r;
  logic                p0_ack_r, p1_ack_r, p0_err_r, p1_err_r;
  logic [DATA_W-1:0]   p0_rdata_r, p1_rdata_r;

  assign req_s = {p1_req, p0_req};

  rr_arbiter2 u_arb (
    .req        (req_s),
    .last_grant (last_grant_r),
    .grant      (grant_s)
  );

  // Mux the winning port's request fields
  always_comb begin
    if (grant_s) begin
      sel_we_s    = p1_we;
      sel_byte_s  = p1_byte;
      sel_addr_s  = p1_addr;
      sel_wdata_s = p1_wdata;
    end else begin
      sel_we_s    = p0_we;
      sel_byte_s  = p0_byte;
      sel_addr_s  = p0_addr;
      sel_wdata_s = p0_wdata;
    end
  end

  assign sel_err_s = addr_err(sel_addr_s, sel_byte_s);
  // Byte loads come back zero-extended whatever the memory drives above bit 7.
  assign rd_s = mem_byte_r ? {24'h000000, mem_read_data[7:0]} : mem_read_data;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req_s) next_state_s = ACCESS;
        else        next_state_s = IDLE;
      end
      ACCESS:  next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request latch, memory strobes and per-port responses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r     <= 1'b1;
      win_r            <= 1'b0;
      err_r            <= 1'b0;
      mem_address_r    <= '0;
      mem_write_data_r <= '0;
      mem_byte_r       <= 1'b0;
      mem_read_r       <= 1'b0;
      mem_write_r      <= 1'b0;
      p0_ack_r         <= 1'b0;
      p1_ack_r         <= 1'b0;
      p0_err_r         <= 1'b0;
      p1_err_r         <= 1'b0;
      p0_rdata_r       <= '0;
      p1_rdata_r       <= '0;
    end else begin
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      p0_ack_r    <= 1'b0;
      p1_ack_r    <= 1'b0;
      p0_err_r    <= 1'b0;
      p1_err_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|req_s) begin
            win_r            <= grant_s;
            last_grant_r     <= grant_s;
            err_r            <= sel_err_s;
            mem_address_r    <= sel_addr_s;
            mem_write_data_r <= sel_byte_s ? {24'h000000, sel_wdata_s[7:0]} : sel_wdata_s;
            mem_byte_r       <= sel_byte_s;
            mem_read_r       <= !sel_we_s && !sel_err_s;
            mem_write_r      <= sel_we_s && !sel_err_s;
          end
        end
        ACCESS: begin
          if (win_r) begin
            p1_rdata_r <= rd_s;
            p1_ack_r   <= 1'b1;
            p1_err_r   <= err_r;
          end else begin
            p0_rdata_r <= rd_s;
            p0_ack_r   <= 1'b1;
            p0_err_r   <= err_r;
          end
        end
        RESP:    ;
        default: ;
      endcase
    end
  end

  assign mem_address    = mem_address_r;
  assign mem_write_data = mem_write_data_r;
  assign mem_read       = mem_read_r;
  assign mem_write      = mem_write_r;
  assign mem_byte       = mem_byte_r;
  assign p0_ack         = p0_ack_r;
  assign p1_ack         = p1_ack_r;
  assign p0_err         = p0_err_r;
  assign p1_err         = p1_err_r;
  assign p0_rdata       = p0_rdata_r;
  assign p1_rdata       = p1_rdata_r;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed plus randomized bench for mem_access_arbiter with a byte-array
// memory and a behavioural expectation model.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p0_byte, p1_req, p1_we, p1_byte;
  logic [17:0] p0_addr, p1_addr, mem_address;
  logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic [31:0] mem_write_data, mem_read_data;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic        mem_read, mem_write, mem_byte;

  logic [7:0]  mem     [0:255];
  logic [7:0]  ref_mem [0:255];
  logic [31:0] exp_rd  [0:1];
  bit          known   [0:1];

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, wr_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, dual_cnt = 0;

  mem_access_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_byte(p0_byte), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_byte(p1_byte), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte(mem_byte),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory block: combinational read, little-endian words
  always_comb begin
    mem_read_data = 32'h0;
    if (mem_address <= 18'd252)
      mem_read_data = {mem[mem_address[7:0] + 8'd3], mem[mem_address[7:0] + 8'd2],
                       mem[mem_address[7:0] + 8'd1], mem[mem_address[7:0]]};
    else if (mem_address <= 18'd255)
      mem_read_data = {24'h0, mem[mem_address[7:0]]};
    else
      mem_read_data = 32'h0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_write && mem_address <= 18'd255) begin
      if (mem_byte) mem[mem_address[7:0]] <= mem_write_data[7:0];
      else if (mem_address <= 18'd252) begin
        mem[mem_address[7:0]]        <= mem_write_data[7:0];
        mem[mem_address[7:0] + 8'd1] <= mem_write_data[15:8];
        mem[mem_address[7:0] + 8'd2] <= mem_write_data[23:16];
        mem[mem_address[7:0] + 8'd3] <= mem_write_data[31:24];
      end
    end
  end

  // Activity counters sampled on the falling edge
  always @(negedge clk) begin
    if (mem_read)         rd_cnt   <= rd_cnt + 1;
    if (mem_write)        wr_cnt   <= wr_cnt + 1;
    if (p0_ack)           ack0_cnt <= ack0_cnt + 1;
    if (p1_ack)           ack1_cnt <= ack1_cnt + 1;
    if (p0_ack && p1_ack) dual_cnt <= dual_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int p = 0; p < 2; p++) begin
      known[p]  = 1'b1;
      exp_rd[p] = 32'h0;
    end
  endtask

  // One access on one port, started just after a rising edge with the FSM idle
  task automatic do_access(input bit port, input bit we, input bit bt,
                           input logic [17:0] addr, input logic [31:0] wdata);
    int a, lat, rd0, wr0, own0, oth0;
    bit got, e;
    logic [31:0] want;
    a    = int'(addr);
    e    = (a >= 256) || (!bt && (a % 4) != 0);
    want = 32'h0;
    if (!e && !we)
      want = bt ? {24'h0, ref_mem[a]} : {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    if (!e && we) begin
      if (bt) ref_mem[a] = wdata[7:0];
      else begin
        ref_mem[a] = wdata[7:0];    ref_mem[a+1] = wdata[15:8];
        ref_mem[a+2] = wdata[23:16]; ref_mem[a+3] = wdata[31:24];
      end
    end
    rd0  = rd_cnt;
    wr0  = wr_cnt;
    own0 = port ? ack1_cnt : ack0_cnt;
    oth0 = port ? ack0_cnt : ack1_cnt;
    if (port) begin
      p1_we = we; p1_byte = bt; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_byte = bt; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (port ? p1_ack : p0_ack) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk("ack_latency", 32'(lat), 32'd3);
    if (got) begin
      chk("err", 32'(port ? p1_err : p0_err), 32'(e));
      if (!e && !we) chk("rdata", port ? p1_rdata : p0_rdata, want);
    end
    @(posedge clk);
    #1;
    if (port) p1_req = 1'b0;
    else      p0_req = 1'b0;
    chk("read_strobes",  32'(rd_cnt - rd0), 32'(!e && !we));
    chk("write_strobes", 32'(wr_cnt - wr0), 32'(!e && we));
    chk("winner_acks",   32'((port ? ack1_cnt : ack0_cnt) - own0), 32'd1);
    chk("loser_acks",    32'((port ? ack0_cnt : ack1_cnt) - oth0), 32'd0);
    if (known[!port]) chk("loser_rdata", port ? p0_rdata : p1_rdata, exp_rd[!port]);
    known[port]  = !e && !we;
    exp_rd[port] = want;
  endtask

  initial begin
    int n, d0, a0;
    bit got;
    logic [17:0] ra;

    reset  = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_byte = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_byte = 1'b0; p1_addr = '0; p1_wdata = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p0_ack", 32'(p0_ack), 32'd0);
    chk("rst_p1_ack", 32'(p1_ack), 32'd0);
    chk("rst_err", 32'(p0_err | p1_err), 32'd0);
    chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    chk("rst_p1_rdata", p1_rdata, 32'h0);
    reset = 1'b0;

    // Word store/load, then byte store/load over it
    do_access(1'b1, 1'b1, 1'b0, 18'h010, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 1'b0, 18'h010, 32'h0);
    chk("s1_lw", p1_rdata, 32'hDEADBEEF);
    do_access(1'b1, 1'b1, 1'b1, 18'h013, 32'hAAAAAA55);
    do_access(1'b1, 1'b0, 1'b1, 18'h013, 32'h0);
    chk("s2_lb", p1_rdata, 32'h00000055);
    do_access(1'b1, 1'b0, 1'b0, 18'h010, 32'h0);
    chk("s2_lw", p1_rdata, 32'h55ADBEEF);

    // Rejected accesses and the top-of-memory boundary
    do_access(1'b1, 1'b0, 1'b0, 18'h0FE, 32'h0);
    do_access(1'b1, 1'b0, 1'b0, 18'h100, 32'h0);
    do_access(1'b1, 1'b1, 1'b1, 18'h101, 32'h12345678);
    do_access(1'b0, 1'b1, 1'b0, 18'h0FC, 32'h11223344);
    do_access(1'b0, 1'b0, 1'b0, 18'h0FC, 32'h0);
    chk("s5_lw_top", p0_rdata, 32'h11223344);
    do_access(1'b0, 1'b0, 1'b0, 18'h0FD, 32'h0);
    do_access(1'b0, 1'b0, 1'b1, 18'h0FF, 32'h0);
    chk("s5_lb_top", p0_rdata, 32'h00000011);

    // Both ports requesting continuously from reset alternate p0, p1, p0, p1
    reset = 1'b1;
    p0_we = 1'b0; p0_byte = 1'b0; p0_addr = 18'h010; p0_req = 1'b1;
    p1_we = 1'b0; p1_byte = 1'b0; p1_addr = 18'h0FC; p1_req = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    d0 = dual_cnt;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      n = 0;
      while (!got && n < 8) begin
        @(negedge clk);
        n++;
        if (p0_ack || p1_ack) got = 1'b1;
      end
      chk("s3_ack_spacing", 32'(n), 32'd3);
      chk("s3_p0_grant", 32'(p0_ack), 32'((k % 2) == 0));
      chk("s3_p1_grant", 32'(p1_ack), 32'((k % 2) == 1));
    end
    @(posedge clk);
    #1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    chk("s3_dual_acks", 32'(dual_cnt - d0), 32'd0);
    chk("s3_p0_rdata", p0_rdata, 32'h0);

    // Reset in the middle of an access abandons it
    p1_we = 1'b0; p1_byte = 1'b0; p1_addr = 18'h010; p1_req = 1'b1;
    @(posedge clk);
    #1;
    chk("s6_read_in_access", 32'(mem_read), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("s6_read_dropped", 32'(mem_read), 32'd0);
    p1_req = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    a0 = ack0_cnt + ack1_cnt;
    repeat (5) @(negedge clk);
    chk("s6_no_ack", 32'(ack0_cnt + ack1_cnt - a0), 32'd0);
    @(posedge clk);
    #1;
    p0_we = 1'b0; p0_byte = 1'b1; p0_addr = 18'h000; p0_req = 1'b1;
    p1_req = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (p0_ack || p1_ack) got = 1'b1;
    end
    chk("s6_first_p0", 32'(p0_ack), 32'd1);
    chk("s6_first_not_p1", 32'(p1_ack), 32'd0);
    @(posedge clk);
    #1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(posedge clk);
    #1;

    // Randomized single-port traffic against the model
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) != 0) ra = 18'($urandom_range(0, 63) * 4);
      else                           ra = 18'($urandom_range(0, 271));
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ra, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
